// File: rtl/mcp4922_pkg.sv
// mcp4922_pkg: shared definitions for the MCP4922 DAC command word.
// The transmitter and the receiver both use this package. It holds the
// word and value widths, the bit positions of the control fields, a
// channel enum, and a helper that splits a command word into the fields
// for one channel.
package mcp4922_pkg;

  localparam int MCP_WORD_W   = 16;
  localparam int MCP_VALUE_W  = 12;

  localparam int MCP_AB_BIT   = 15;  // 0 = channel A, 1 = channel B
  localparam int MCP_BUF_BIT  = 14;  // reference input buffer enable
  localparam int MCP_GA_BIT   = 13;  // 1 = 1x gain, 0 = 2x gain
  localparam int MCP_SHDN_BIT = 12;  // 1 = channel active

  // The receiver's bit counter saturates one count past a full word.
  // Over-length frames therefore stay distinguishable from good ones.
  localparam int MCP_CNT_MAX  = MCP_WORD_W + 1;

  typedef enum logic {
    MCP_CH_A = 1'b0,
    MCP_CH_B = 1'b1
  } mcp_chan_e;

  typedef struct packed {
    logic [MCP_VALUE_W-1:0] value;
    logic                   buffered;
    logic                   gain_1x;
    logic                   shdn;
  } mcp_chan_cfg_t;

  function automatic mcp_chan_e mcp_channel(input logic [MCP_WORD_W-1:0] w);
    return mcp_chan_e'(w[MCP_AB_BIT]);
  endfunction

  function automatic mcp_chan_cfg_t mcp_decode(input logic [MCP_WORD_W-1:0] w);
    mcp_chan_cfg_t cfg;
    cfg.value    = w[MCP_VALUE_W-1:0];
    cfg.buffered = w[MCP_BUF_BIT];
    cfg.gain_1x  = w[MCP_GA_BIT];
    cfg.shdn     = w[MCP_SHDN_BIT];
    return cfg;
  endfunction

endpackage

// File: rtl/mcp4922_rx_sync_edge.sv
// sync_edge: pin synchronizer with edge detection.
// The asynchronous input d passes through STAGES flops. The last stage is
// the synchronized level. The level is compared against one extra
// registered copy to produce one-cycle rise and fall pulses.
// Every instance has the same depth, so the relative timing of the pins
// is preserved.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   d          : asynchronous pin input
//   level      : synchronized level
//   rise, fall : one-cycle pulses on a synchronized 0->1 / 1->0 change
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage;
  logic              prev;

  // NOTE: sequential state always uses non-blocking assignments, so that
  // every flop in the chain samples the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
      prev  <= 1'b0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
      prev <= stage[STAGES-1];
    end
  end

  assign level = stage[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/mcp4922_rx.sv
// mcp4922_rx: receiver for the MCP4922 DAC serial command protocol.
// The receiver oversamples cs_n/sck/sdi in the clk domain. It collects
// 16-bit MSB-first frames, sampling on sck rising edges, and decodes each
// good frame into the value and configuration registers of the addressed
// channel.
// Optional feature: define MCP4922_RX_LDAC_EN to add the ldac_n pin.
// With it, decoded frames load per-channel input latches, and these
// latches are copied to the outputs while ldac_n is low.
// Ports:
//   clk, reset           : system clock, synchronous active-high reset
//   cs_n, sck, sdi       : asynchronous serial pins
//   ldac_n               : load-DAC pin (only with MCP4922_RX_LDAC_EN)
//   word                 : last complete raw frame
//   word_valid/frame_err : one-cycle pulses on good / bad frame close
//   busy                 : frame in progress (armed and cs_n low)
//   dac_*, buf_*, ga_*, shdn_*, active_* : per-channel decoded outputs
module mcp4922_rx
  import mcp4922_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_n,
  input  logic                   sck,
  input  logic                   sdi,
`ifdef MCP4922_RX_LDAC_EN
  input  logic                   ldac_n,
`endif
  output logic [MCP_WORD_W-1:0]  word,
  output logic                   word_valid,
  output logic                   frame_err,
  output logic                   busy,
  output logic [MCP_VALUE_W-1:0] dac_a,
  output logic [MCP_VALUE_W-1:0] dac_b,
  output logic                   buf_a,
  output logic                   buf_b,
  output logic                   ga_a,
  output logic                   ga_b,
  output logic                   shdn_a,
  output logic                   shdn_b,
  output logic                   active_a,
  output logic                   active_b
);

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_ARMED = 1'b1
  } rx_state_e;

  localparam logic [4:0] CNT_FULL = 5'(MCP_WORD_W);
  localparam logic [4:0] CNT_SAT  = 5'(MCP_CNT_MAX);

  // Pin synchronizers
  logic cs_level, cs_rise, cs_fall;
  logic sck_rise;
  logic sdi_level;
  logic sck_level_unused, sck_fall_unused;
  logic sdi_rise_unused, sdi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .d(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .reset(reset), .d(sdi),
    .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  // Frame FSM
  rx_state_e state, state_next;
  logic      do_arm, do_shift, do_close;

  always_ff @(posedge clk) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so that no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    do_arm     = 1'b0;
    do_shift   = 1'b0;
    do_close   = 1'b0;
    unique case (state)
      // A cs_n that is already low out of reset never produces a fall.
      // Such a frame is therefore ignored until cs_n goes high and low again.
      RX_IDLE: begin
        if (cs_fall) begin
          state_next = RX_ARMED;
          do_arm     = 1'b1;
        end
      end
      // On a cs_n rise, cs_level is already high. An sck rise in the same
      // cycle is therefore not shifted.
      RX_ARMED: begin
        if (cs_rise) begin
          state_next = RX_IDLE;
          do_close   = 1'b1;
        end else if (sck_rise && !cs_level) begin
          do_shift = 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign busy = (state == RX_ARMED) && !cs_level;

  // Shift register, bit counter and frame close
  logic [MCP_WORD_W-1:0] shreg;
  logic [4:0]            bit_cnt;
  logic                  frame_ok, frame_bad;
  mcp_chan_cfg_t         ch_a, ch_b;   // decoded registers / input latches
  mcp_chan_cfg_t         out_a, out_b; // what the pins present

  assign frame_ok  = do_close && (bit_cnt == CNT_FULL);
  assign frame_bad = do_close && (bit_cnt != CNT_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      ch_a       <= '0;
      ch_b       <= '0;
    end else begin
      word_valid <= frame_ok;
      frame_err  <= frame_bad;

      if (do_arm) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (do_shift) begin
        shreg <= {shreg[MCP_WORD_W-2:0], sdi_level};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
      end

      if (frame_ok) begin
        word <= shreg;
        if (mcp_channel(shreg) == MCP_CH_B) ch_b <= mcp_decode(shreg);
        else                                ch_a <= mcp_decode(shreg);
      end
    end
  end

`ifdef MCP4922_RX_LDAC_EN
  logic ldac_level;
  logic ldac_rise_unused, ldac_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ldac (
    .clk(clk), .reset(reset), .d(ldac_n),
    .level(ldac_level), .rise(ldac_rise_unused), .fall(ldac_fall_unused)
  );

  // Level-sensitive transfer. A frame that decodes while ldac_n is low
  // reaches the outputs one cycle after it lands in the input latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_a <= '0;
      out_b <= '0;
    end else if (!ldac_level) begin
      out_a <= ch_a;
      out_b <= ch_b;
    end
  end
`else
  assign out_a = ch_a;
  assign out_b = ch_b;
`endif

  assign dac_a    = out_a.value;
  assign buf_a    = out_a.buffered;
  assign ga_a     = out_a.gain_1x;
  assign shdn_a   = out_a.shdn;
  assign active_a = out_a.shdn;

  assign dac_b    = out_b.value;
  assign buf_b    = out_b.buffered;
  assign ga_b     = out_b.gain_1x;
  assign shdn_b   = out_b.shdn;
  assign active_b = out_b.shdn;

endmodule
